write_module: RTL and testbench
===============================

Name: write_module

Overview:
Write-side producer for the dual-clock FIFO, sitting directly upstream of the FIFO write port in the wclk domain.
- Accepts 16-bit words from a source over a valid/ready handshake and holds them in a small internal buffer.
- Drains the buffer into the FIFO via winc/wdata, honouring wfull, so that no word is lost or duplicated.
- Exposes a running count of words committed to the FIFO and a stall flag for debug.

Parameters:
DATA_W, 16, width of in_data/wdata
BUF_DEPTH, 4, internal buffer entries; must be a power of 2 and >= 2
CNT_W, 16, width of wr_count

Ports:
wclk  in  1  write-domain clock; all logic on rising edge
Wrst_n  in  1  asynchronous, active-low reset
in_data  in  DATA_W  source data word
in_valid  in  1  source has a word on in_data
in_ready  out  1  block can accept a word this cycle
wfull  in  1  FIFO full flag (wclk domain)
winc  out  1  FIFO write enable; FIFO writes wdata at the rising wclk edge when winc=1
wdata  out  DATA_W  word presented to the FIFO
wr_count  out  CNT_W  number of words written to the FIFO, wraps modulo 2^CNT_W
stall  out  1  buffer holds data but the FIFO is full

Behaviour:
Reset
- Wrst_n low clears all state immediately, independent of wclk.
- Buffer count=0; read and write pointers=0; state=IDLE; wr_count=0.
- Outputs while Wrst_n is low: winc=0, wdata=0, stall=0, in_ready=0 (forced).
- Reset mid-transfer discards all buffered words. No winc pulse may occur during or after assertion.

Buffer
- Circular buffer of BUF_DEPTH x DATA_W, with write/read pointers of log2(BUF_DEPTH) bits that wrap naturally.
- Count register is log2(BUF_DEPTH)+1 bits wide.

Handshake
- in_ready is registered; it is 1 when count < BUF_DEPTH, and is also 1 when count == BUF_DEPTH-1 even if a pop is not occurring.
- in_ready is updated each cycle from the next-state count.
- push = in_valid & in_ready: on that edge, in_data is stored at the write pointer, which then increments.
- in_data is ignored when in_ready=0.

FIFO side
- winc = (count != 0) & ~wfull, combinational. It is never 1 while wfull=1.
- wdata = entry at the read pointer when count != 0; 0 when empty.
- pop = winc: on that edge, the read pointer increments and wr_count increments by 1, wrapping FFFF -> 0000 for CNT_W=16.
- Latency: a word pushed at edge N can be presented with winc=1 in the cycle after edge N, and written at edge N+1 if wfull=0.

Simultaneous events
- push and pop on the same edge: count unchanged; both pointers advance.
- Full buffer (count=BUF_DEPTH): in_ready=0, so no push occurs even if a pop occurs that cycle. A slot freed by a pop is re-offered the following cycle.

State machine (status only; drives stall)
- IDLE: count=0.
- ACTIVE: count>0 & ~wfull.
- BLOCKED: count>0 & wfull.
- Transitions are evaluated every edge from the next count and the current wfull. Any state may move directly to any other.
- stall=1 only in BLOCKED, registered.

Ordering
- Words reach the FIFO in exactly the order accepted. No drops, no duplicates.

Test Plan:
- Reset then idle, wfull=0, no in_valid -> winc=0, wdata=0, in_ready=1 one cycle after release, wr_count=0, stall=0.
- Single word: push 16'hA5A5 with wfull=0 -> next cycle winc=1, wdata=A5A5; after that edge winc=0 and wr_count=1.
- Back-to-back stream: push 0x0001..0x0010 on consecutive cycles with wfull=0 -> in_ready stays 1, winc is 1 on 16 consecutive cycles, FIFO receives 0x0001..0x0010 in order, wr_count=16.
- Backpressure: wfull=1 while pushing 0x0100..0x0105 -> winc=0, stall=1, in_ready drops after 4 accepted words (0x0100..0x0103). Release wfull -> 0x0100..0x0103 written in order, then 0x0104 and 0x0105 are accepted and written; no loss.
- wfull toggling each cycle during a 20-word stream -> winc is never 1 while wfull=1, all 20 words arrive in order, wr_count=20.
- Wrst_n low asynchronously mid-stream with 3 words buffered -> winc, stall and wr_count drop to 0 immediately. After release, new word 0x00FF is the first written and wr_count=1.
- Preload wr_count to 0xFFFE via 65534 writes, then write 3 words -> wr_count=0x0001.

Source files
------------

// File: rtl/write_module.sv
// write_module: wclk-domain producer feeding the dual-clock FIFO.
// Buffers source words and drains them through winc/wdata.
module write_module #(
  parameter int DATA_W    = 16,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic              wclk,
  input  logic              Wrst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wfull,
  output logic              winc,
  output logic [DATA_W-1:0] wdata,
  output logic [CNT_W-1:0]  wr_count,
  output logic              stall
);

  localparam int PW = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [PW:0]       count;
  logic [PW:0]       count_nx;
  logic              rdy_q;
  logic              push;
  logic              pop;
  logic              busy;
  state_t            state;
  state_t            state_nx;

  assign busy     = (count != '0);
  assign winc     = busy & ~wfull;
  assign wdata    = busy ? mem[rptr] : '0;
  assign in_ready = rdy_q;
  assign push     = in_valid & rdy_q;
  assign pop      = winc;

  // Occupancy after this edge; push+pop together leaves it unchanged.
  always_comb begin
    count_nx = count;
    unique case ({push, pop})
      2'b10:   count_nx = count + (PW+1)'(1);
      2'b01:   count_nx = count - (PW+1)'(1);
      default: count_nx = count;
    endcase
  end

  // Buffer storage, written at the write pointer on accept.
  always_ff @(posedge wclk) begin
    if (push) mem[wptr] <= in_data;
  end

  // Pointers, occupancy, registered ready and commit counter.
  always_ff @(posedge wclk or negedge Wrst_n) begin
    if (!Wrst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rdy_q    <= 1'b0;
      wr_count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop) begin
        rptr     <= rptr + PW'(1);
        wr_count <= wr_count + CNT_W'(1);
      end
      count <= count_nx;
      // Top bit set only when the buffer is completely full.
      rdy_q <= ~count_nx[PW];
    end
  end

  // Status state register.
  always_ff @(posedge wclk or negedge Wrst_n) begin
    if (!Wrst_n) state <= IDLE;
    else         state <= state_nx;
  end

  // Next status from next occupancy and current full flag.
  always_comb begin
    state_nx = IDLE;
    unique case (1'b1)
      (count_nx == '0):          state_nx = IDLE;
      (count_nx != '0) && wfull:  state_nx = BLOCKED;
      (count_nx != '0) && !wfull: state_nx = ACTIVE;
      default:                    state_nx = IDLE;
    endcase
  end

  // Stall output decoded from the registered status.
  always_comb begin
    stall = (state == BLOCKED);
  end

endmodule

// File: tb/tb_write_module.sv
// tb_write_module: randomized and directed checks of write_module
// against a queue-based model of the buffered word stream.
module tb_write_module;

  logic        wclk = 1'b0;
  logic        Wrst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wfull;
  logic        winc;
  logic [15:0] wdata;
  logic [15:0] wr_count;
  logic        stall;

  int total = 0;
  int bad   = 0;

  logic [15:0] mq[$];
  logic        m_rdy;
  logic        m_stall;
  logic [15:0] m_cnt;

  always #5 wclk = ~wclk;

  write_module #(
    .DATA_W(16),
    .BUF_DEPTH(4),
    .CNT_W(16)
  ) dut (
    .wclk(wclk),
    .Wrst_n(Wrst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .wfull(wfull),
    .winc(winc),
    .wdata(wdata),
    .wr_count(wr_count),
    .stall(stall)
  );

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdy   = 1'b0;
    m_stall = 1'b0;
    m_cnt   = 16'h0;
  endtask

  // One clock: drive inputs, check outputs, advance the model.
  task automatic step(input logic v, input logic [15:0] d,
                      input logic f, output logic acc);
    logic        ew;
    logic [15:0] ed;
    in_valid = v;
    in_data  = d;
    wfull    = f;
    #1;
    ew = (mq.size() != 0) && !f;
    ed = (mq.size() != 0) ? mq[0] : 16'h0;
    chk("winc", winc, ew);
    chk("wdata", wdata, ed);
    chk("in_ready", in_ready, m_rdy);
    chk("stall", stall, m_stall);
    chk("wr_count", wr_count, m_cnt);
    acc = v && m_rdy;
    @(posedge wclk);
    if (ew) begin
      void'(mq.pop_front());
      m_cnt++;
    end
    if (acc) mq.push_back(d);
    m_rdy   = (mq.size() < 4);
    m_stall = (mq.size() != 0) && f;
    @(negedge wclk);
  endtask

  // fmode: 0 never full, 1 toggling, 2 full for 8 cycles, 4 always full
  task automatic stream(input logic [15:0] base, input int n,
                        input int fmode, input int budget);
    int   sent;
    logic f;
    logic acc;
    sent = 0;
    for (int c = 0; c < budget && sent < n; c++) begin
      case (fmode)
        1:       f = c[0];
        2:       f = (c < 8);
        4:       f = 1'b1;
        default: f = 1'b0;
      endcase
      step(1'b1, 16'(base + sent), f, acc);
      if (acc) sent++;
    end
    chk("stream_sent", sent, n);
  endtask

  task automatic drain();
    logic acc;
    for (int c = 0; c < 20 && mq.size() != 0; c++)
      step(1'b0, 16'h0, 1'b0, acc);
    step(1'b0, 16'h0, 1'b0, acc);
    chk("drained_winc", winc, 1'b0);
  endtask

  task automatic do_reset();
    Wrst_n = 1'b0;
    #1;
    chk("rst_winc", winc, 1'b0);
    chk("rst_wdata", wdata, 16'h0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_wr_count", wr_count, 16'h0);
    model_reset();
    @(negedge wclk);
    Wrst_n = 1'b1;
  endtask

  initial begin
    logic        acc;
    logic [15:0] base;
    in_valid = 1'b0;
    in_data  = 16'h0;
    wfull    = 1'b0;
    do_reset();

    // Idle after release: ready rises one cycle later.
    step(1'b0, 16'h0, 1'b0, acc);
    step(1'b0, 16'h0, 1'b0, acc);
    chk("idle_in_ready", in_ready, 1'b1);

    // Single word.
    step(1'b1, 16'hA5A5, 1'b0, acc);
    chk("single_winc", winc, 1'b1);
    chk("single_wdata", wdata, 16'hA5A5);
    drain();
    chk("single_count", wr_count, 16'd1);

    // Back-to-back stream of 16 words.
    stream(16'h0001, 16, 0, 20);
    drain();
    chk("b2b_count", wr_count, 16'd17);

    // Backpressure: full for 8 cycles while offering 6 words.
    stream(16'h0100, 6, 2, 40);
    drain();
    chk("bp_count", wr_count, 16'd23);

    // Full toggling each cycle over 20 words.
    stream(16'h0300, 20, 1, 80);
    drain();
    chk("tog_count", wr_count, 16'd43);

    // Random valid/data/full.
    for (int c = 0; c < 300; c++)
      step(1'($urandom_range(0, 1)), 16'($urandom),
           1'($urandom_range(0, 2) == 0), acc);
    drain();

    // Reset mid-stream with three words buffered.
    stream(16'h0200, 3, 4, 10);
    in_valid = 1'b0;
    wfull    = 1'b0;
    #1;
    chk("pre_rst_winc", winc, 1'b1);
    do_reset();
    stream(16'h00FF, 1, 0, 5);
    step(1'b0, 16'h0, 1'b0, acc);
    chk("post_rst_winc", winc, 1'b0);
    chk("post_rst_count", wr_count, 16'd1);

    // Counter wrap: preload to FFFE then three more.
    do_reset();
    base = 16'h0;
    stream(base, 65534, 0, 65600);
    drain();
    chk("preload_count", wr_count, 16'hFFFE);
    stream(16'h7000, 3, 0, 10);
    drain();
    chk("wrap_count", wr_count, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
